// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution frame controller.
// Holds the FSM encoding and counter width helper.
package conv_pkg;

    localparam int IMG_W_DEF = 502;
    localparam int IMG_H_DEF = 502;
    localparam int CH_DEF    = 3;
    localparam int K_DEF     = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KERNEL,
        S_PIXEL,
        S_DRAIN,
        S_DONE
    } state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_frame_ctrl_pos_counter.sv
// Nested chan/col/row position counter for one pixel frame.
// last_o flags the increment of the frame's final byte.
module pos_counter
    import conv_pkg::*;
#(
    parameter int W = IMG_W_DEF,
    parameter int H = IMG_H_DEF,
    parameter int C = CH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [cnt_w(W)-1:0]   col_o,
    output logic [cnt_w(H)-1:0]   row_o,
    output logic                  last_o
);

    localparam int CHW = cnt_w(C);
    localparam int CW  = cnt_w(W);
    localparam int RW  = cnt_w(H);

    localparam logic [CHW-1:0] CH_END  = CHW'(C - 1);
    localparam logic [CW-1:0]  COL_END = CW'(W - 1);
    localparam logic [RW-1:0]  ROW_END = RW'(H - 1);

    logic [CHW-1:0] chan_q, chan_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic           chan_end, col_end, row_end;

    assign chan_end = (chan_q == CH_END);
    assign col_end  = (col_q == COL_END);
    assign row_end  = (row_q == ROW_END);
    assign last_o   = inc_i && chan_end && col_end && row_end;
    assign col_o    = col_q;
    assign row_o    = row_q;

    // Next position: channel wraps into column, column into row.
    always_comb begin
        chan_d = chan_q;
        col_d  = col_q;
        row_d  = row_q;
        if (clr_i) begin
            chan_d = '0;
            col_d  = '0;
            row_d  = '0;
        end else if (inc_i) begin
            if (chan_end) begin
                chan_d = '0;
                if (col_end) begin
                    col_d = '0;
                    row_d = row_end ? '0 : row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end else begin
                chan_d = chan_q + CHW'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chan_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            chan_q <= chan_d;
            col_q  <= col_d;
            row_q  <= row_d;
        end
    end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: kernel load, pixel stream, drain, done.
// Issues compute/transmit strobes and tracks overrun errors.
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int CH    = CH_DEF,
    parameter int K     = K_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic rx_valid,
    input  logic send_busy,
    output logic kernel_we,
    output logic pixel_we,
    output logic cal_we,
    output logic send_we,
    output logic frame_done,
    output logic busy,
    output logic err_overrun
);

    localparam int KB = K * K * CH;
    localparam int KW = cnt_w(KB);
    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);

    localparam logic [KW-1:0] K_LAST = KW'(KB - 1);
    localparam logic [CW-1:0] COL_TH = CW'(K - 1);
    localparam logic [RW-1:0] ROW_TH = RW'(K - 1);

    state_e        state_q, state_d;
    logic [KW-1:0] kcnt_q, kcnt_d;
    logic          cal_q, cal_d;
    logic          send_q, send_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    logic          pos_clr, pos_inc, pos_last;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    pos_counter #(
        .W (IMG_W),
        .H (IMG_H),
        .C (CH)
    ) u_pos (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (pos_clr),
        .inc_i  (pos_inc),
        .col_o  (col),
        .row_o  (row),
        .last_o (pos_last)
    );

    // Next state, counter control, strobe requests and error flag.
    always_comb begin
        state_d = state_q;
        kcnt_d  = kcnt_q;
        err_d   = err_q;
        cal_d   = 1'b0;
        send_d  = 1'b0;
        last_d  = 1'b0;
        pos_clr = 1'b0;
        pos_inc = 1'b0;
        if (send_q && send_busy) err_d = 1'b1;
        if (abort) begin
            state_d = S_IDLE;
            kcnt_d  = '0;
            pos_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_KERNEL;
                        kcnt_d  = '0;
                        pos_clr = 1'b1;
                        err_d   = 1'b0;
                    end
                end
                S_KERNEL: begin
                    if (rx_valid) begin
                        if (kcnt_q == K_LAST) begin
                            kcnt_d  = '0;
                            state_d = S_PIXEL;
                        end else begin
                            kcnt_d = kcnt_q + KW'(1);
                        end
                    end
                end
                S_PIXEL: begin
                    if (last_q) begin
                        state_d = S_DRAIN;
                        if (rx_valid) err_d = 1'b1;
                    end else if (rx_valid) begin
                        pos_inc = 1'b1;
                        cal_d   = 1'b1;
                        send_d  = (row >= ROW_TH) && (col >= COL_TH);
                        last_d  = pos_last;
                    end
                end
                S_DRAIN: begin
                    if (rx_valid) err_d = 1'b1;
                    if (!send_busy) state_d = S_DONE;
                end
                S_DONE: begin
                    if (rx_valid) err_d = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, kernel count, strobe pipeline and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            kcnt_q  <= '0;
            cal_q   <= 1'b0;
            send_q  <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kcnt_q  <= kcnt_d;
            cal_q   <= cal_d;
            send_q  <= send_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign kernel_we   = (state_q == S_KERNEL);
    assign pixel_we    = (state_q == S_PIXEL);
    assign frame_done  = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign cal_we      = cal_q;
    assign send_we     = send_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl, 4x3 image, 3x3 kernel.
// Instance 0 runs CH=1, instance 1 runs CH=3.
module tb_conv_frame_ctrl;

    typedef struct packed {
        logic s;
        logic d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start_v = '0;
    logic [1:0] abort_v = '0;
    logic [1:0] rx_v = '0;
    logic [1:0] sb_v = '0;
    logic [1:0] kwe, pwe, cal, snd, fd, bsy, err;

    int   tests = 0;
    int   fails = 0;
    int   drain_cnt = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    conv_frame_ctrl #(.IMG_W(4), .IMG_H(3), .CH(1), .K(3)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .rx_valid(rx_v[0]), .send_busy(sb_v[0]),
        .kernel_we(kwe[0]), .pixel_we(pwe[0]), .cal_we(cal[0]),
        .send_we(snd[0]), .frame_done(fd[0]), .busy(bsy[0]),
        .err_overrun(err[0])
    );

    conv_frame_ctrl #(.IMG_W(4), .IMG_H(3), .CH(3), .K(3)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .rx_valid(rx_v[1]), .send_busy(sb_v[1]),
        .kernel_we(kwe[1]), .pixel_we(pwe[1]), .cal_we(cal[1]),
        .send_we(snd[1]), .frame_done(fd[1]), .busy(bsy[1]),
        .err_overrun(err[1])
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Transmit expected for pixel byte n (0-based) of a 4-wide image.
    function automatic logic exp_send(input int n, input int ch);
        int p;
        p = n / ch;
        return ((p / 4) >= 2) && ((p % 4) >= 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s, input logic sv, input logic dv);
        exp_t e;
        e.s = sv;
        e.d = dv;
        if (s == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic pulse_start(input int s);
        start_v[s] = 1'b1;
        tick();
        start_v[s] = 1'b0;
    endtask

    task automatic send_byte(input int s);
        rx_v[s] = 1'b1;
        tick();
        rx_v[s] = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int s);
        int n;
        n = 0;
        while (bsy[s] && n < 100) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, bsy[s]}, 0);
    endtask

    task automatic load_kernel(input int s, input int ch);
        pulse_start(s);
        check("kernel_we", {31'd0, kwe[s]}, 1);
        for (int i = 0; i < 9 * ch; i++) send_byte(s);
        check("pixel_we", {31'd0, pwe[s]}, 1);
    endtask

    task automatic run_frame(input int s, input int ch, input bit mid_start);
        load_kernel(s, ch);
        for (int n = 0; n < 12 * ch; n++) begin
            push(s, exp_send(n, ch), 1'b0);
            if (n == 12 * ch - 1) push(s, 1'b0, 1'b1);
            send_byte(s);
            if (mid_start && n == 4) begin
                pulse_start(s);
                check("start_in_pixel_pwe", {31'd0, pwe[s]}, 1);
                check("start_in_pixel_kwe", {31'd0, kwe[s]}, 0);
            end
        end
        wait_idle(s);
    endtask

    // Scoreboard monitor: every strobe or done pulse pops one entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (cal[i] || snd[i] || fd[i]) begin
                    if ((i == 0 && q0.size() == 0) ||
                        (i == 1 && q1.size() == 0)) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_out dut%0d: cal=%0b send=%0b done=%0b expected none",
                                 i, cal[i], snd[i], fd[i]);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        tests++;
                        if (cal[i] !== !e.d || snd[i] !== e.s || fd[i] !== e.d) begin
                            fails++;
                            $display("FAIL strobe dut%0d: cal=%0b send=%0b done=%0b expected %0b %0b %0b",
                                     i, cal[i], snd[i], fd[i], !e.d, e.s, e.d);
                        end
                    end
                end
            end
        end
    end

    // Cycles spent draining on instance 0.
    always @(negedge clk) begin
        if (bsy[0] && !kwe[0] && !pwe[0] && !fd[0]) drain_cnt++;
    end

    initial begin
        start_v = 2'b11;
        rx_v = 2'b11;
        abort_v = 2'b00;
        repeat (3) tick();
        check("rst_outputs", {18'd0, kwe, pwe, cal, snd, fd, bsy, err}, 0);
        start_v = '0;
        rx_v = '0;
        rst = 1'b0;
        tick();

        // Byte in idle is ignored.
        send_byte(0);
        check("idle_rx_busy", {31'd0, bsy[0]}, 0);
        check("idle_rx_err", {31'd0, err[0]}, 0);

        // Normal frame with a stray start mid-stream.
        run_frame(0, 1, 1'b1);
        check("frame1_err", {31'd0, err[0]}, 0);

        // CH=3 frame.
        run_frame(1, 3, 1'b0);
        check("ch3_err", {31'd0, err[1]}, 0);

        // Abort after five pixel bytes.
        load_kernel(0, 1);
        for (int n = 0; n < 5; n++) begin
            push(0, exp_send(n, 1), 1'b0);
            send_byte(0);
        end
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        check("abort_busy", {31'd0, bsy[0]}, 0);
        check("abort_pwe", {31'd0, pwe[0]}, 0);
        for (int n = 0; n < 3; n++) send_byte(0);
        run_frame(0, 1, 1'b0);
        check("post_abort_err", {31'd0, err[0]}, 0);

        // Transmitter busy at result bytes and through drain.
        load_kernel(0, 1);
        for (int n = 0; n < 11; n++) begin
            if (n == 10) sb_v[0] = 1'b1;
            push(0, exp_send(n, 1), 1'b0);
            send_byte(0);
        end
        push(0, 1'b1, 1'b0);
        push(0, 1'b0, 1'b1);
        drain_cnt = 0;
        rx_v[0] = 1'b1;
        tick();
        rx_v[0] = 1'b0;
        repeat (10) tick();
        sb_v[0] = 1'b0;
        tick();
        check("done_after_busy", {31'd0, fd[0]}, 1);
        wait_idle(0);
        check("drain_cycles", drain_cnt, 10);
        check("overrun_set", {31'd0, err[0]}, 1);
        repeat (3) tick();
        check("overrun_held", {31'd0, err[0]}, 1);
        pulse_start(0);
        check("overrun_clear", {31'd0, err[0]}, 0);
        abort_v[0] = 1'b1;
        pulse_start(0);
        abort_v[0] = 1'b0;
        check("abort_beats_start", {31'd0, bsy[0]}, 0);

        // Byte arriving after the last pixel byte.
        load_kernel(1, 3);
        for (int n = 0; n < 36; n++) begin
            push(1, exp_send(n, 3), 1'b0);
            if (n == 35) push(1, 1'b0, 1'b1);
            rx_v[1] = 1'b1;
            tick();
            if (n != 35) begin
                rx_v[1] = 1'b0;
                tick();
            end
        end
        tick();
        rx_v[1] = 1'b0;
        wait_idle(1);
        check("late_rx_err", {31'd0, err[1]}, 1);

        repeat (4) tick();
        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_frame_ctrl.md
CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

Interface
REQ-001 Parameter IMG_W, default 502, image width in pixels.
REQ-002 Parameter IMG_H, default 502, image height in pixels.
REQ-003 Parameter CH, default 3, bytes (channels) per pixel, interleaved.
REQ-004 Parameter K, default 3, kernel edge; kernel byte count KB = K*K*CH.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  one-cycle frame-begin request.
REQ-008 abort  in  1  cancel the current frame.
REQ-009 rx_valid  in  1  one-cycle strobe per received UART byte.
REQ-010 send_busy  in  1  transmitter busy.
REQ-011 kernel_we  out  1  kernel loader enable.
REQ-012 pixel_we  out  1  pixel receive enable.
REQ-013 cal_we  out  1  one-cycle shift/compute strobe per pixel byte.
REQ-014 send_we  out  1  one-cycle transmit strobe per valid result byte.
REQ-015 frame_done  out  1  one-cycle end-of-frame pulse.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 err_overrun  out  1  sticky error flag.

Function
REQ-018 FSM states SHALL be IDLE, KERNEL, PIXEL, DRAIN, DONE.
REQ-019 IDLE: start -> KERNEL; byte, channel, column and row counters cleared; err_overrun cleared.
REQ-020 KERNEL: kernel_we=1; each rx_valid increments the kernel count; the KB-th byte -> PIXEL.
REQ-021 PIXEL: pixel_we=1; each rx_valid SHALL produce cal_we exactly one cycle later, one cycle wide.
REQ-022 Position counters SHALL nest chan (0..CH-1), col (0..IMG_W-1), row (0..IMG_H-1); each wraps to 0 and carries to the next.
REQ-023 send_we SHALL pulse in the same cycle as cal_we when the byte's row >= K-1 and col >= K-1; total pulses per frame = (IMG_W-K+1)*(IMG_H-K+1)*CH.
REQ-024 send_we pulse while send_busy=1 SHALL set err_overrun; the pulse is still issued.
REQ-025 Byte at row=IMG_H-1, col=IMG_W-1, chan=CH-1 SHALL move PIXEL -> DRAIN after its strobes.
REQ-026 DRAIN: wait for send_busy=0 -> DONE. DONE: frame_done=1 for one cycle -> IDLE.
REQ-027 rx_valid in DRAIN or DONE SHALL set err_overrun; rx_valid in IDLE is ignored.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 abort in any state SHALL force IDLE next cycle; enables and strobes drop, counters clear, err_overrun holds.
REQ-030 abort and start in the same cycle: abort wins.
REQ-031 Counter widths SHALL be $clog2 of each range, minimum 1 bit.

Reset
REQ-032 rst SHALL set state IDLE, clear all counters, and drive all outputs to 0, including err_overrun.
REQ-033 rst SHALL take priority over start, abort and rx_valid.

Structure
REQ-034 Shared package conv_pkg SHALL hold the state enumeration and default IMG_W/IMG_H/CH/K constants.
REQ-035 One sub-module, pos_counter, SHALL implement the parameterised chan/col/row nested wrap counter with a carry-out on the frame's last byte.

Verification
REQ-036 IMG_W=4, IMG_H=3, CH=1, K=3: start, 9 kernel bytes, 12 pixel bytes -> 12 cal_we pulses, send_we on pixel bytes 11 and 12 only, frame_done once.
REQ-037 Same sizes, CH=3: KB=27, 36 pixel bytes -> 6 send_we pulses, on pixel bytes 31-36.
REQ-038 abort after 5 pixel bytes -> IDLE next cycle, no further send_we; a new start runs a full clean frame.
REQ-039 send_busy=1 at a send_we pulse -> err_overrun=1, held until the next start.
REQ-040 send_busy held 10 cycles after the last byte -> DRAIN for 10 cycles, frame_done one cycle after busy falls.
REQ-041 rx_valid in IDLE and start in PIXEL -> no state change, no strobes, counters unchanged.
